// File: rtl/sdram_pmem_arb2_if.sv
// pmem-style request/response bundle shared by requesters and the SDRAM core.
// master drives wr/rd/len/addr/write_data; slave returns accept/ack/error/read_data.
interface sdram_pmem_arb2_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [3:0]            wr;
    logic                  rd;
    logic [7:0]            len;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  accept;
    logic                  ack;
    logic                  error;
    logic [DATA_WIDTH-1:0] read_data;

    modport master (
        output wr, rd, len, addr, write_data,
        input  accept, ack, error, read_data
    );

    modport slave (
        input  wr, rd, len, addr, write_data,
        output accept, ack, error, read_data
    );
endinterface

// File: rtl/sdram_pmem_arb2.sv
// Two-port round-robin pmem arbiter with burst lock and in-order ack routing.
// Ports: clk_i, rst_i (async, high), p0/p1 (slave requesters), ram (master to SDRAM core).
module sdram_pmem_arb2 #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_DEPTH  = 4,
    parameter int TAG_ADDR_W = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    sdram_pmem_arb2_if.slave  p0,
    sdram_pmem_arb2_if.slave  p1,
    sdram_pmem_arb2_if.master ram
);

    localparam logic [0:0] ST_UNLOCKED = 1'b0;
    localparam logic [0:0] ST_LOCKED   = 1'b1;

    localparam logic [TAG_ADDR_W:0] DEPTH_C = (TAG_ADDR_W+1)'(TAG_DEPTH);

    logic [0:0]            state_q;
    logic                  owner_q;
    logic                  last_q;
    logic                  hold_q;
    logic                  hold_port_q;
    logic [7:0]            beats_left_q;
    logic [TAG_DEPTH-1:0]  tag_q;
    logic [TAG_ADDR_W-1:0] wr_ptr_q;
    logic [TAG_ADDR_W-1:0] rd_ptr_q;
    logic [TAG_ADDR_W:0]   count_q;

    logic                  req0, req1;
    logic                  gnt_v, gnt;
    logic                  sel_req;
    logic [3:0]            sel_wr;
    logic                  sel_rd;
    logic [7:0]            sel_len;
    logic                  fifo_nonempty;
    logic                  pop;
    logic                  fifo_full;
    logic                  can_issue;
    logic                  accept_beat;
    logic                  stalled;
    logic                  head;

    assign req0 = (|p0.wr) | p0.rd;
    assign req1 = (|p1.wr) | p1.rd;

    always_comb begin
        gnt_v = 1'b0;
        gnt   = 1'b0;
        priority case (1'b1)
            (state_q == ST_LOCKED): begin
                gnt_v = 1'b1;
                gnt   = owner_q;
            end
            hold_q: begin
                gnt_v = 1'b1;
                gnt   = hold_port_q;
            end
            (req0 && req1): begin
                gnt_v = 1'b1;
                gnt   = ~last_q;
            end
            req0: begin
                gnt_v = 1'b1;
                gnt   = 1'b0;
            end
            req1: begin
                gnt_v = 1'b1;
                gnt   = 1'b1;
            end
            default: begin
                gnt_v = 1'b0;
                gnt   = 1'b0;
            end
        endcase
    end

    assign sel_req = gnt ? req1 : req0;
    assign sel_wr  = gnt ? p1.wr : p0.wr;
    assign sel_rd  = gnt ? p1.rd : p0.rd;
    assign sel_len = gnt ? p1.len : p0.len;

    assign fifo_nonempty = (count_q != '0);
    assign pop           = ram.ack && fifo_nonempty;
    // A same-cycle ack frees a slot, so acceptance resumes without a bubble.
    assign fifo_full     = (count_q == DEPTH_C) && !pop;

    assign can_issue   = gnt_v && !fifo_full;
    assign accept_beat = can_issue && sel_req && ram.accept;
    assign stalled     = gnt_v && sel_req && !accept_beat;

    assign ram.wr         = can_issue ? sel_wr : 4'b0;
    assign ram.rd         = can_issue ? sel_rd : 1'b0;
    assign ram.len        = sel_len;
    assign ram.addr       = gnt ? p1.addr : p0.addr;
    assign ram.write_data = gnt ? p1.write_data : p0.write_data;

    assign p0.accept = accept_beat && !gnt;
    assign p1.accept = accept_beat && gnt;

    assign head         = tag_q[rd_ptr_q];
    assign p0.ack       = pop && !head;
    assign p1.ack       = pop && head;
    assign p0.error     = pop && !head && ram.error;
    assign p1.error     = pop && head && ram.error;
    assign p0.read_data = ram.read_data;
    assign p1.read_data = ram.read_data;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_UNLOCKED;
            owner_q      <= 1'b0;
            last_q       <= 1'b1;
            hold_q       <= 1'b0;
            hold_port_q  <= 1'b0;
            beats_left_q <= 8'd0;
        end else begin
            hold_q <= stalled;
            if (stalled) begin
                hold_port_q <= gnt;
            end
            if (accept_beat) begin
                if (state_q == ST_UNLOCKED) begin
                    last_q <= gnt;
                    if (sel_len != 8'd0) begin
                        state_q      <= ST_LOCKED;
                        owner_q      <= gnt;
                        beats_left_q <= sel_len;
                    end
                end else begin
                    beats_left_q <= beats_left_q - 8'd1;
                    if (beats_left_q == 8'd1) begin
                        state_q <= ST_UNLOCKED;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tag_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept_beat) begin
                tag_q[wr_ptr_q] <= gnt;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (accept_beat && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !accept_beat) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(ram.ack && !fifo_nonempty))
                else $warning("stray ram ack with no outstanding tag dropped");
        end
    end
`endif

endmodule

// File: tb/tb_sdram_pmem_arb2.sv
// Directed bench for sdram_pmem_arb2: single beat, contention, burst lock,
// stall hold, tag FIFO full, and reset mid-burst.
module tb_sdram_pmem_arb2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    sdram_pmem_arb2_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) p0_if ();
    sdram_pmem_arb2_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) p1_if ();
    sdram_pmem_arb2_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ram_if ();

    sdram_pmem_arb2 #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TAG_DEPTH(4),
        .TAG_ADDR_W(2)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .p0(p0_if),
        .p1(p1_if),
        .ram(ram_if)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        p0_if.wr = 4'h0; p0_if.rd = 1'b0; p0_if.len = 8'd0;
        p0_if.addr = 32'h0; p0_if.write_data = 32'h0;
        p1_if.wr = 4'h0; p1_if.rd = 1'b0; p1_if.len = 8'd0;
        p1_if.addr = 32'h0; p1_if.write_data = 32'h0;
        ram_if.accept = 1'b0; ram_if.ack = 1'b0;
        ram_if.error = 1'b0; ram_if.read_data = 32'h0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        #12;
        chk("rst_ram_rd", ram_if.rd, 1'b0);
        chk("rst_ram_wr", ram_if.wr, 4'h0);
        chk("rst_ram_addr", ram_if.addr, 32'h0);
        chk("rst_p0_acc", p0_if.accept, 1'b0);
        chk("rst_p1_acc", p1_if.accept, 1'b0);
        chk("rst_p0_ack", p0_if.ack, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // single port read
        p0_if.rd = 1'b1; p0_if.addr = 32'h100; ram_if.accept = 1'b1;
        #1;
        chk("single_ram_rd", ram_if.rd, 1'b1);
        chk("single_ram_addr", ram_if.addr, 32'h100);
        chk("single_p0_acc", p0_if.accept, 1'b1);
        chk("single_p1_acc", p1_if.accept, 1'b0);
        step();
        idle();
        step();
        ram_if.ack = 1'b1; ram_if.read_data = 32'hDEADBEEF;
        #1;
        chk("single_p0_ack", p0_if.ack, 1'b1);
        chk("single_p1_ack", p1_if.ack, 1'b0);
        chk("single_p0_data", p0_if.read_data, 32'hDEADBEEF);
        step();
        idle();

        // fresh reset so contention starts from last_q=1
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();

        // contention, one ack per cycle for the previous beat
        p0_if.rd = 1'b1; p0_if.addr = 32'h10;
        p1_if.rd = 1'b1; p1_if.addr = 32'h20;
        ram_if.accept = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ram_if.ack = (i > 0);
            #1;
            chk($sformatf("cont_p0_acc_%0d", i), p0_if.accept, (i % 2) == 0);
            chk($sformatf("cont_p1_acc_%0d", i), p1_if.accept, (i % 2) == 1);
            chk($sformatf("cont_addr_%0d", i), ram_if.addr,
                ((i % 2) == 0) ? 32'h10 : 32'h20);
            if (i > 0) begin
                chk($sformatf("cont_p0_ack_%0d", i), p0_if.ack, (i % 2) == 1);
                chk($sformatf("cont_p1_ack_%0d", i), p1_if.ack, (i % 2) == 0);
            end
            step();
        end
        idle();
        ram_if.ack = 1'b1;
        #1;
        chk("cont_p1_ack_last", p1_if.ack, 1'b1);
        chk("cont_p0_ack_last", p0_if.ack, 1'b0);
        step();
        idle();

        // burst lock: p1 len=3 write, p0 asks from the second cycle
        p1_if.wr = 4'hF; p1_if.len = 8'd3; p1_if.addr = 32'h200;
        ram_if.accept = 1'b1;
        #1;
        chk("burst_p1_acc_0", p1_if.accept, 1'b1);
        chk("burst_ram_wr_0", ram_if.wr, 4'hF);
        step();
        p0_if.rd = 1'b1; p0_if.addr = 32'h280;
        ram_if.ack = 1'b1;
        for (int i = 1; i < 4; i++) begin
            #1;
            chk($sformatf("burst_p1_acc_%0d", i), p1_if.accept, 1'b1);
            chk($sformatf("burst_p0_acc_%0d", i), p0_if.accept, 1'b0);
            chk($sformatf("burst_p1_ack_%0d", i), p1_if.ack, 1'b1);
            step();
        end
        p1_if.wr = 4'h0;
        #1;
        chk("burst_p0_acc_after", p0_if.accept, 1'b1);
        chk("burst_ram_rd_after", ram_if.rd, 1'b1);
        chk("burst_addr_after", ram_if.addr, 32'h280);
        step();
        idle();
        ram_if.ack = 1'b1;
        #1;
        chk("burst_p0_ack", p0_if.ack, 1'b1);
        step();
        idle();

        // stall hold: p0 stalled, p1 joins, grant must not move
        p0_if.rd = 1'b1; p0_if.addr = 32'h300;
        #1;
        chk("hold_addr_0", ram_if.addr, 32'h300);
        chk("hold_p0_acc_0", p0_if.accept, 1'b0);
        step();
        p1_if.rd = 1'b1; p1_if.addr = 32'h400;
        #1;
        chk("hold_addr_1", ram_if.addr, 32'h300);
        chk("hold_p1_acc_1", p1_if.accept, 1'b0);
        step();
        #1;
        chk("hold_addr_2", ram_if.addr, 32'h300);
        step();
        ram_if.accept = 1'b1;
        #1;
        chk("hold_p0_acc_3", p0_if.accept, 1'b1);
        chk("hold_p1_acc_3", p1_if.accept, 1'b0);
        step();
        p0_if.rd = 1'b0;
        #1;
        chk("hold_p1_acc_4", p1_if.accept, 1'b1);
        step();
        idle();
        ram_if.ack = 1'b1;
        #1;
        chk("hold_p0_ack", p0_if.ack, 1'b1);
        step();
        #1;
        chk("hold_p1_ack", p1_if.ack, 1'b1);
        step();
        idle();

        // tag FIFO full
        p0_if.rd = 1'b1; p0_if.addr = 32'h500; ram_if.accept = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("full_p0_acc_%0d", i), p0_if.accept, 1'b1);
            step();
        end
        p1_if.rd = 1'b1; p1_if.addr = 32'h600;
        #1;
        chk("full_ram_rd", ram_if.rd, 1'b0);
        chk("full_ram_wr", ram_if.wr, 4'h0);
        chk("full_p0_acc", p0_if.accept, 1'b0);
        chk("full_p1_acc", p1_if.accept, 1'b0);
        step();
        ram_if.ack = 1'b1;
        #1;
        chk("full_resume_p1_acc", p1_if.accept, 1'b1);
        chk("full_resume_ram_rd", ram_if.rd, 1'b1);
        chk("full_resume_p0_ack", p0_if.ack, 1'b1);
        step();
        idle();
        ram_if.ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("full_drain_p1_ack_%0d", i), p1_if.ack, i == 3);
            step();
        end
        idle();

        // reset mid-burst
        p0_if.rd = 1'b1; p0_if.len = 8'd7; p0_if.addr = 32'h700;
        ram_if.accept = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("mid_p0_acc_%0d", i), p0_if.accept, 1'b1);
            step();
        end
        idle();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        ram_if.ack = 1'b1;
        #1;
        chk("mid_stray_p0_ack", p0_if.ack, 1'b0);
        chk("mid_stray_p1_ack", p1_if.ack, 1'b0);
        step();
        idle();
        p0_if.rd = 1'b1; p0_if.addr = 32'h800;
        p1_if.rd = 1'b1; p1_if.addr = 32'h900;
        ram_if.accept = 1'b1;
        #1;
        chk("mid_cont_p0_acc", p0_if.accept, 1'b1);
        chk("mid_cont_p1_acc", p1_if.accept, 1'b0);
        chk("mid_cont_addr", ram_if.addr, 32'h800);
        step();
        idle();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
